// File: rtl/mips_exc_ctrl.sv
`timescale 1ns/1ps
// mips_exc_ctrl: exception / ERET sequencer for the 5-stage MIPS64 pipeline.
// Owns CP0 Status(12), Cause(13), EPC(14). A taken event runs
// IDLE -> FLUSH -> REDIRECT and then steers the PC to the vector or EPC.
// Optional build macro EXC_TIMER_IRQ_EN adds Count(9)/Compare(11) and IP7.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | sampling events; normal pipeline flow
// FLUSH    | squashing IF/ID/EX, counter runs down to 0
// REDIRECT | redirect_pc is loaded into the PC this cycle
module mips_exc_ctrl #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(64'h0000_0000_8000_0180),
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  id_valid_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic                  except_i,
    input  logic                  syscall_i,
    input  logic                  eret_i,
    input  logic                  ex_valid_i,
    input  logic [DATA_WIDTH-1:0] ex_pc_i,
    input  logic                  ex_overflow_i,
    input  logic                  irq_i,
    input  logic                  cp0_wr_en_i,
    input  logic [4:0]            cp0_addr_i,
    input  logic [DATA_WIDTH-1:0] cp0_wdata_i,
    output logic [DATA_WIDTH-1:0] cp0_rdata_o,
    output logic                  flush_o,
    output logic                  stall_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic                  exl_o
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;

    logic                  ie_q, ie_d;
    logic                  exl_q, exl_d;
    logic [7:0]            im_q, im_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic                  ip2_q;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic                  ip7;

    logic [7:0]            ip;
    logic                  is_idle;
    logic                  ev_ov, ev_ri, ev_sys, ev_eret, ev_int;
    logic                  trap_take, eret_take, event_take;
    logic [4:0]            trap_code;
    logic [DATA_WIDTH-1:0] victim_pc;
    logic [31:0]           status_rd, cause_rd;
    logic                  wr_status, wr_cause, wr_epc;

    assign ip      = {ip7, 4'b0000, ip2_q, ip_sw_q};
    assign is_idle = (state_q == S_IDLE);

    assign ev_ov   = ex_valid_i & ex_overflow_i;
    assign ev_ri   = id_valid_i & except_i;
    assign ev_sys  = id_valid_i & syscall_i;
    assign ev_eret = id_valid_i & eret_i;
    assign ev_int  = ie_q & ~exl_q & (|(ip & im_q));

    // ERET outranks a pending interrupt but loses to any synchronous trap
    assign trap_take  = is_idle & (ev_ov | ev_ri | ev_sys | (ev_int & ~ev_eret));
    assign eret_take  = is_idle & ev_eret & ~(ev_ov | ev_ri | ev_sys);
    assign event_take = trap_take | eret_take;

    // Pick the winning cause code and the PC of the squashed instruction
    always_comb begin
        trap_code = EXC_INT;
        victim_pc = id_pc_i;
        if (ev_ov) begin
            trap_code = EXC_OV;
            victim_pc = ex_pc_i;
        end else if (ev_ri) begin
            trap_code = EXC_RI;
        end else if (ev_sys) begin
            trap_code = EXC_SYS;
        end
    end

    // Sequencer next-state: latch target on entry, count flush cycles down
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        unique case (state_q)
            S_IDLE: begin
                if (event_take) begin
                    state_d  = S_FLUSH;
                    cnt_d    = CW'(FLUSH_CYCLES - 1);
                    target_d = trap_take ? EXC_VECTOR : epc_q;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign flush_o          = event_take | (state_q == S_FLUSH);
    assign stall_o          = ~is_idle | event_take;
    assign redirect_valid_o = (state_q == S_REDIRECT);
    assign redirect_pc_o    = target_q;
    assign epc_o            = epc_q;
    assign exl_o            = exl_q;

    assign wr_status = cp0_wr_en_i & (cp0_addr_i == A_STATUS);
    assign wr_cause  = cp0_wr_en_i & (cp0_addr_i == A_CAUSE);
    assign wr_epc    = cp0_wr_en_i & (cp0_addr_i == A_EPC);

    // CP0 next-state: MTC0 first, then trap/ERET overrides the fields it owns
    always_comb begin
        ie_d      = ie_q;
        exl_d     = exl_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        ip_sw_d   = ip_sw_q;
        epc_d     = epc_q;
        if (wr_status) begin
            ie_d  = cp0_wdata_i[0];
            exl_d = cp0_wdata_i[1];
            im_d  = cp0_wdata_i[15:8];
        end
        if (wr_cause) begin
            ip_sw_d = cp0_wdata_i[9:8];
        end
        if (wr_epc) begin
            epc_d = cp0_wdata_i;
        end
        if (trap_take) begin
            exccode_d = trap_code;
            exl_d     = 1'b1;
            if (!exl_q) begin
                epc_d = victim_pc;
            end
        end
        if (eret_take) begin
            exl_d = 1'b0;
        end
    end

    // Sequencer and CP0 state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= '0;
            exccode_q <= '0;
            ip_sw_q   <= '0;
            ip2_q     <= 1'b0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            exccode_q <= exccode_d;
            ip_sw_q   <= ip_sw_d;
            ip2_q     <= irq_i;
            epc_q     <= epc_d;
        end
    end

    assign status_rd = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
    assign cause_rd  = {16'h0000, ip, 1'b0, exccode_q, 2'b00};

`ifdef EXC_TIMER_IRQ_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q, ip7_d;

    // Free-running Count; match uses the pre-increment value, IP7 clears on Compare write
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ip7_d     = ip7_q;
        if (count_q == compare_q) begin
            ip7_d = 1'b1;
        end
        if (cp0_wr_en_i && (cp0_addr_i == A_COUNT)) begin
            count_d = cp0_wdata_i[31:0];
        end
        if (cp0_wr_en_i && (cp0_addr_i == A_COMPARE)) begin
            compare_d = cp0_wdata_i[31:0];
            ip7_d     = 1'b0;
        end
    end

    // Timer registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q   <= '0;
            compare_q <= '0;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign ip7 = ip7_q;

    // CP0 read port, zero-extended
    always_comb begin
        cp0_rdata_o = '0;
        case (cp0_addr_i)
            A_COUNT:   cp0_rdata_o = DATA_WIDTH'(count_q);
            A_COMPARE: cp0_rdata_o = DATA_WIDTH'(compare_q);
            A_STATUS:  cp0_rdata_o = DATA_WIDTH'(status_rd);
            A_CAUSE:   cp0_rdata_o = DATA_WIDTH'(cause_rd);
            A_EPC:     cp0_rdata_o = epc_q;
            default:   cp0_rdata_o = '0;
        endcase
    end
`else
    assign ip7 = 1'b0;

    // CP0 read port, zero-extended; Count/Compare are absent and read as 0
    always_comb begin
        cp0_rdata_o = '0;
        case (cp0_addr_i)
            A_STATUS: cp0_rdata_o = DATA_WIDTH'(status_rd);
            A_CAUSE:  cp0_rdata_o = DATA_WIDTH'(cause_rd);
            A_EPC:    cp0_rdata_o = epc_q;
            default:  cp0_rdata_o = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_mips_exc_ctrl.sv
`timescale 1ns/1ps
// Bench for mips_exc_ctrl: table of trap/ERET scenarios with a redirect
// scoreboard, plus hand sequences for MTC0, reset abort and the timer.
module tb_mips_exc_ctrl;

    localparam int          FC  = 2;
    localparam logic [63:0] VEC = 64'h0000_0000_8000_0180;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        id_valid_i = 1'b0;
    logic [63:0] id_pc_i = '0;
    logic        except_i = 1'b0;
    logic        syscall_i = 1'b0;
    logic        eret_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [63:0] ex_pc_i = '0;
    logic        ex_overflow_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        cp0_wr_en_i = 1'b0;
    logic [4:0]  cp0_addr_i = 5'd13;
    logic [63:0] cp0_wdata_i = '0;
    logic [63:0] cp0_rdata_o;
    logic        flush_o, stall_o, redirect_valid_o, exl_o;
    logic [63:0] redirect_pc_o, epc_o;

    mips_exc_ctrl #(.DATA_WIDTH(64), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .except_i(except_i), .syscall_i(syscall_i), .eret_i(eret_i),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_overflow_i(ex_overflow_i),
        .irq_i(irq_i), .cp0_wr_en_i(cp0_wr_en_i), .cp0_addr_i(cp0_addr_i),
        .cp0_wdata_i(cp0_wdata_i), .cp0_rdata_o(cp0_rdata_o),
        .flush_o(flush_o), .stall_o(stall_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .epc_o(epc_o), .exl_o(exl_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0] status;
        logic [63:0] epc;
        logic        id_valid, exc, sys, eret;
        logic [63:0] id_pc;
        logic        ex_valid, ex_ov;
        logic [63:0] ex_pc;
        logic        irq;
        logic        taken;
        logic [63:0] exp_rpc, exp_epc;
        logic        exp_exl;
        logic [4:0]  exp_code;
    } vec_t;

    typedef struct {
        logic [63:0] rpc, epc;
        logic        exl;
        logic [4:0]  code;
        int          t;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] status, input logic [63:0] epc,
                                input logic idv, input logic exc, input logic sys, input logic er,
                                input logic [63:0] idpc, input logic exv, input logic ov,
                                input logic [63:0] expc, input logic irq, input logic taken,
                                input logic [63:0] rpc, input logic [63:0] xepc,
                                input logic xexl, input logic [4:0] code);
        vec_t v;
        v.status = status; v.epc = epc; v.id_valid = idv; v.exc = exc; v.sys = sys;
        v.eret = er; v.id_pc = idpc; v.ex_valid = exv; v.ex_ov = ov; v.ex_pc = expc;
        v.irq = irq; v.taken = taken; v.exp_rpc = rpc; v.exp_epc = xepc;
        v.exp_exl = xexl; v.exp_code = code;
        return v;
    endfunction

    // Scoreboard: every redirect must match the oldest pending expectation
    always @(negedge clk_i) begin
        if (!reset_i && redirect_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_redirect", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("redirect_pc", redirect_pc_o, e.rpc);
                chk("redirect_epc", epc_o, e.epc);
                chk("redirect_exl", {63'd0, exl_o}, {63'd0, e.exl});
                chk("redirect_exccode", {59'd0, cp0_rdata_o[6:2]}, {59'd0, e.code});
                chk("redirect_latency", 64'(cyc_cnt - e.t), 64'(FC + 1));
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            chk({name, "_redirect_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [63:0] d);
        @(posedge clk_i); #1;
        cp0_wr_en_i = 1'b1; cp0_addr_i = a; cp0_wdata_i = d;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [63:0] exp);
        @(posedge clk_i); #1;
        cp0_wr_en_i = 1'b0; cp0_addr_i = a;
        @(negedge clk_i);
        chk(name, cp0_rdata_o, exp);
        cp0_addr_i = 5'd13;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        mtc0(5'd12, 64'd0);
        mtc0(5'd14, v.epc);
        mtc0(5'd12, {32'd0, v.status});
        irq_i = v.irq;
        @(posedge clk_i); #1;
        cp0_wr_en_i = 1'b0; cp0_addr_i = 5'd13;
        id_valid_i = v.id_valid; except_i = v.exc; syscall_i = v.sys; eret_i = v.eret;
        id_pc_i = v.id_pc; ex_valid_i = v.ex_valid; ex_overflow_i = v.ex_ov; ex_pc_i = v.ex_pc;
        @(negedge clk_i);
        chk($sformatf("v%0d_flush_T", idx), {63'd0, flush_o}, {63'd0, v.taken});
        chk($sformatf("v%0d_stall_T", idx), {63'd0, stall_o}, {63'd0, v.taken});
        if (v.taken) begin
            e.rpc = v.exp_rpc; e.epc = v.exp_epc; e.exl = v.exp_exl;
            e.code = v.exp_code; e.t = cyc_cnt;
            sb.push_back(e);
        end
        @(posedge clk_i); #1;
        id_valid_i = 1'b0; except_i = 1'b0; syscall_i = 1'b0; eret_i = 1'b0;
        ex_valid_i = 1'b0; ex_overflow_i = 1'b0; irq_i = 1'b0;
        for (int k = 1; k <= FC; k++) begin
            @(negedge clk_i);
            chk($sformatf("v%0d_flush_T%0d", idx, k), {63'd0, flush_o}, {63'd0, v.taken});
        end
        if (v.taken) wait_drain($sformatf("v%0d", idx));
        else repeat (4) @(negedge clk_i);
    endtask

    vec_t vecs[14];

    initial begin
        //             status      epc     idv exc sys er idpc    exv ov expc    irq take rpc     epc     exl code
        vecs[0]  = mk(32'h0000, 64'h000, 1, 1, 0, 0, 64'h100, 0, 0, 64'h000, 0, 1, VEC,     64'h100, 1, 5'd10);
        vecs[1]  = mk(32'h0002, 64'h100, 1, 0, 1, 0, 64'h200, 0, 0, 64'h000, 0, 1, VEC,     64'h100, 1, 5'd8);
        vecs[2]  = mk(32'h0000, 64'h000, 1, 0, 1, 0, 64'h304, 1, 1, 64'h300, 0, 1, VEC,     64'h300, 1, 5'd12);
        vecs[3]  = mk(32'h0002, 64'h104, 1, 0, 0, 1, 64'h500, 0, 0, 64'h000, 0, 1, 64'h104, 64'h104, 0, 5'd12);
        vecs[4]  = mk(32'h0000, 64'h208, 1, 0, 0, 1, 64'h510, 0, 0, 64'h000, 0, 1, 64'h208, 64'h208, 0, 5'd12);
        vecs[5]  = mk(32'h0401, 64'h000, 1, 0, 0, 0, 64'h600, 0, 0, 64'h000, 1, 1, VEC,     64'h600, 1, 5'd0);
        vecs[6]  = mk(32'h0403, 64'h000, 1, 0, 0, 0, 64'h610, 0, 0, 64'h000, 1, 0, VEC,     64'h000, 1, 5'd0);
        vecs[7]  = mk(32'h0001, 64'h000, 1, 0, 0, 0, 64'h620, 0, 0, 64'h000, 1, 0, VEC,     64'h000, 0, 5'd0);
        vecs[8]  = mk(32'h0000, 64'h000, 0, 1, 0, 0, 64'h630, 0, 0, 64'h000, 0, 0, VEC,     64'h000, 0, 5'd0);
        vecs[9]  = mk(32'h0000, 64'h000, 1, 0, 1, 0, 64'h704, 0, 1, 64'h700, 0, 1, VEC,     64'h704, 1, 5'd8);
        vecs[10] = mk(32'h0000, 64'h000, 1, 1, 1, 0, 64'h800, 0, 0, 64'h000, 0, 1, VEC,     64'h800, 1, 5'd10);
        vecs[11] = mk(32'h0000, 64'h000, 1, 0, 1, 1, 64'h810, 0, 0, 64'h000, 0, 1, VEC,     64'h810, 1, 5'd8);
        vecs[12] = mk(32'h0002, 64'h900, 1, 0, 0, 0, 64'h954, 1, 1, 64'h950, 0, 1, VEC,     64'h900, 1, 5'd12);
        vecs[13] = mk(32'h0000, 64'h040, 0, 0, 0, 1, 64'h960, 0, 0, 64'h000, 0, 0, VEC,     64'h000, 0, 5'd0);

        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_flush", {63'd0, flush_o}, 64'd0);
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_redirect", {63'd0, redirect_valid_o}, 64'd0);
        chk("rst_rpc", redirect_pc_o, 64'd0);
        chk("rst_epc", epc_o, 64'd0);
        chk("rst_exl", {63'd0, exl_o}, 64'd0);
        chk("rst_cause", cp0_rdata_o, 64'd0);
        rd_chk("rst_status", 5'd12, 64'd0);

        // MTC0 field masks and unimplemented addresses
        mtc0(5'd13, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("cause_ip_sw_only", 5'd13, 64'h0000_0300);
        mtc0(5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("status_mask", 5'd12, 64'h0000_FF03);
        mtc0(5'd12, 64'd0);
        mtc0(5'd13, 64'd0);
        mtc0(5'd14, 64'h1234_5678_9ABC_DEF0);
        rd_chk("epc_rw", 5'd14, 64'h1234_5678_9ABC_DEF0);
        rd_chk("unimpl_addr", 5'd5, 64'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // MTC0 clearing EXL in the same cycle as a trap: trap wins
        mtc0(5'd12, 64'd0);
        @(posedge clk_i); #1;
        cp0_wr_en_i = 1'b1; cp0_addr_i = 5'd12; cp0_wdata_i = 64'd0;
        id_valid_i = 1'b1; syscall_i = 1'b1; id_pc_i = 64'hB00;
        @(negedge clk_i);
        begin
            exp_t e;
            e.rpc = VEC; e.epc = 64'hB00; e.exl = 1'b1; e.code = 5'd8; e.t = cyc_cnt;
            sb.push_back(e);
        end
        @(posedge clk_i); #1;
        cp0_wr_en_i = 1'b0; cp0_addr_i = 5'd13; id_valid_i = 1'b0; syscall_i = 1'b0;
        @(negedge clk_i);
        chk("mtc0_vs_trap_exl", {63'd0, exl_o}, 64'd1);
        wait_drain("mtc0_vs_trap");

        // Reset in the second FLUSH cycle aborts without a redirect
        @(posedge clk_i); #1;
        id_valid_i = 1'b1; except_i = 1'b1; id_pc_i = 64'h100;
        @(negedge clk_i);
        chk("abort_flush_T", {63'd0, flush_o}, 64'd1);
        @(posedge clk_i); #1;
        id_valid_i = 1'b0; except_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("abort_in_flush", {63'd0, flush_o}, 64'd1);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("abort_redirect", {63'd0, redirect_valid_o}, 64'd0);
        chk("abort_flush", {63'd0, flush_o}, 64'd0);
        chk("abort_stall", {63'd0, stall_o}, 64'd0);
        chk("abort_rpc", redirect_pc_o, 64'd0);
        chk("abort_epc", epc_o, 64'd0);
        chk("abort_exl", {63'd0, exl_o}, 64'd0);
        repeat (4) @(negedge clk_i);

`ifdef EXC_TIMER_IRQ_EN
        begin
            int n;
            mtc0(5'd11, 64'd40);
            mtc0(5'd12, 64'h8001);
            id_pc_i = 64'hA00;
            @(posedge clk_i); #1;
            cp0_wr_en_i = 1'b0; cp0_addr_i = 5'd13;
            n = 0;
            @(negedge clk_i);
            while (!flush_o && n < 80) begin
                @(negedge clk_i);
                n++;
            end
            chk("timer_trap_seen", {63'd0, flush_o}, 64'd1);
            if (flush_o) begin
                exp_t e;
                e.rpc = VEC; e.epc = 64'hA00; e.exl = 1'b1; e.code = 5'd0; e.t = cyc_cnt;
                sb.push_back(e);
                chk("timer_ip7", {63'd0, cp0_rdata_o[15]}, 64'd1);
            end
            wait_drain("timer");
        end
`else
        begin
            int flushes;
            mtc0(5'd9, 64'h55);
            rd_chk("count_absent", 5'd9, 64'd0);
            mtc0(5'd11, 64'd3);
            rd_chk("compare_absent", 5'd11, 64'd0);
            mtc0(5'd12, 64'h8001);
            @(posedge clk_i); #1;
            cp0_wr_en_i = 1'b0; cp0_addr_i = 5'd13;
            flushes = 0;
            repeat (12) begin
                @(negedge clk_i);
                if (flush_o) flushes++;
            end
            chk("no_timer_trap", 64'(flushes), 64'd0);
            chk("no_timer_ip7", {63'd0, cp0_rdata_o[15]}, 64'd0);
        end
`endif

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_exc_ctrl.md
# mips_exc_ctrl

Exception and ERET sequencer for the 5-stage MIPS64 pipeline. It consumes the decoder's `except`, `syscall` and `ERET` flags, the EX-stage overflow flag and an external interrupt line, and owns CP0 Status/Cause/EPC. On a trap it runs a flush → redirect state machine that empties IF/ID/EX and steers the PC to the exception vector, or back to EPC on ERET. It sits beside the hazard unit and drives the PC mux's redirect input.

## Interface
- `DATA_WIDTH`, 64, PC/EPC width
- `EXC_VECTOR`, 64'h0000_0000_8000_0180, trap target PC
- `FLUSH_CYCLES`, 2, cycles `flush` is held in FLUSH state (legal ≥1)
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `id_valid` in 1: ID holds a real, non-bubble instruction
- `id_pc` in DATA_WIDTH: PC of the ID instruction
- `except` in 1: reserved instruction (decoder)
- `syscall` in 1: SYSCALL (decoder)
- `eret` in 1: ERET (decoder)
- `ex_valid` in 1: EX holds a real instruction
- `ex_pc` in DATA_WIDTH: PC of the EX instruction
- `ex_overflow` in 1: signed add/sub overflow in EX
- `irq` in 1: level external interrupt, maps to IP2
- `cp0_wr_en` in 1: MTC0 commit
- `cp0_addr` in 5: CP0 register number (rd field)
- `cp0_wdata` in DATA_WIDTH: MTC0 data
- `cp0_rdata` out DATA_WIDTH: combinational read of `cp0_addr`, zero-extended
- `flush` out 1: squash IF/ID/EX
- `stall` out 1: hold PC and IF/ID
- `redirect_valid` out 1: load `redirect_pc` into PC this cycle
- `redirect_pc` out DATA_WIDTH: target PC
- `epc` out DATA_WIDTH: current EPC
- `exl` out 1: Status.EXL

## Operation
- Registers: Status (12) uses bit0 IE, bit1 EXL, bits15:8 IM. Cause (13) uses bits6:2 ExcCode, bits15:8 IP. EPC (14) is DATA_WIDTH wide. Status and Cause are 32-bit.
- ExcCode values: Int=0, Sys=8, RI=10, Ov=12.
- Events are sampled only in IDLE. Priority, highest first:
  1. `ex_valid&&ex_overflow` (Ov, victim `ex_pc`)
  2. `id_valid&&except` (RI, victim `id_pc`)
  3. `id_valid&&syscall` (Sys, victim `id_pc`)
  4. `id_valid&&eret` (return)
  5. pending interrupt (Int, victim `id_pc`): `IE && !EXL && |(IP & IM)`
- Trap taken:
  - ExcCode is written.
  - EPC is written with the victim PC only if EXL was 0.
  - EXL is set to 1.
  - Target is `EXC_VECTOR`.
- ERET:
  - EXL is cleared.
  - Target is EPC.
  - If EXL is already 0, ERET still redirects to EPC.
- Cause.IP2 follows `irq` every cycle and is not software writable.
- MTC0 is accepted in any state. MTC0 to Status writes IE, EXL and IM. MTC0 to Cause and EPC: EPC is fully writable; Cause writes only IP1:0. A trap/ERET update in the same cycle overrides MTC0 fields it touches.
- Reads of unimplemented addresses return 0.
- FSM states and transitions:
  - IDLE → FLUSH on any taken event; the counter loads FLUSH_CYCLES-1 and the target is latched.
  - FLUSH decrements each cycle; at 0 it moves to REDIRECT.
  - REDIRECT → IDLE unconditionally.
- Output decode:
  - `flush` = event taken in IDLE (combinational) or state==FLUSH.
  - `stall` = state!=IDLE or event taken in IDLE.
  - `redirect_valid` = state==REDIRECT.
- Inputs in FLUSH/REDIRECT are ignored, apart from MTC0 and IP2 tracking.
- `reset` mid-sequence aborts to IDLE with no redirect.

## Timing
- All outputs and registers are 0 after reset. The FSM is in IDLE and the counter is 0.
- Trap latency (event sampled at cycle T):
  - `flush`/`stall` are high in T and in T+1..T+FLUSH_CYCLES.
  - `redirect_valid` is high in T+FLUSH_CYCLES+1.
  - Normal fetch resumes at T+FLUSH_CYCLES+2.
- Status, Cause and EPC update on the T→T+1 edge, so `epc`/`exl` are visible at T+1.
- `redirect_pc` is stable from T+1 until REDIRECT ends.
- Overflow and an ID event in the same cycle: only Ov is taken; the ID instruction is squashed.
- The Compare match check uses the pre-increment Count.

## Configuration
- `EXC_TIMER_IRQ_EN` defined:
  - Count (9) increments every cycle, wrapping at 2^32.
  - Compare (11) is writable.
  - Count==Compare sets IP7 (Cause bit15), which holds until Compare is written.
  - MTC0 to Count overrides the increment for that cycle.
- `EXC_TIMER_IRQ_EN` undefined: Count/Compare read 0, writes are ignored, and IP7 is constant 0.

## Test plan
- RI: `id_valid=1, except=1, id_pc=0x100` in IDLE with EXL=0 → `flush` high 3 cycles. Then `redirect_valid` for 1 cycle with `redirect_pc=0x80000180`, `epc=0x100`, ExcCode=10, `exl=1`.
- Nested trap: `syscall` at `id_pc=0x200` while EXL=1 and EPC=0x100 → redirect to the vector, EPC stays 0x100, ExcCode=8.
- Simultaneous events: `ex_overflow` (`ex_pc=0x300`) with `syscall` (`id_pc=0x304`) → ExcCode=12, EPC=0x300, exactly one redirect.
- ERET: EPC=0x104, EXL=1, `eret=1` → redirect to 0x104 after 2 flush cycles, `exl=0`.
- IRQ gating:
  - Status=0x0401 (IE, IM2), `irq=1` → trap, ExcCode=0.
  - Same setup with EXL=1, or Status=0x0001 → no trap.
- Reset abort: assert `reset` in the second FLUSH cycle → next cycle IDLE, all outputs 0, no `redirect_valid`.
- Timer (`EXC_TIMER_IRQ_EN` defined): Compare=5, Status=0x8001 from reset → IP7 set when Count is 5, then trap. Rebuild without the macro → Count reads 0 and no trap.
